// File: rtl/fairy_wb_stage_pkg.sv
// fairy_wb_stage_pkg
//   Shared definitions for the writeback stage: opcode/funct constants,
//   CP0 register numbers, ExcCode values, the ERET encoding, the Status
//   write mask and a small instruction-decode helper.
//   The optional CP0 timer is enabled by defining FAIRY_CP0_TIMER_EN.
package fairy_wb_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_COP0    = 6'b010000;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MTLO    = 6'b010011;

    localparam logic [4:0] RS_MF = 5'b00000;
    localparam logic [4:0] RS_MT = 5'b00100;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] INST_ERET = 32'h42000018;

    // Status bits an MTC0 can set: IE[0], EXL[1], IM[15:8]; all others
    // (including BEV) read back as 0 after a software write.
    localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;

    typedef struct packed {
        logic       dest_valid;
        logic [4:0] dest;
        logic       is_mfc0;
        logic       is_mtc0;
        logic       is_eret;
        logic       is_sys;
        logic       is_bp;
        logic       is_load;
    } dec_t;

    function automatic dec_t decode_inst(input logic [31:0] inst);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        d  = '0;
        op = inst[31:26];
        fn = inst[5:0];
        rs = inst[25:21];
        if (op == OP_SPECIAL) begin
            d.dest_valid = !((fn == FN_JR) || (fn == FN_SYSCALL) || (fn == FN_BREAK) ||
                             (fn == FN_MTHI) || (fn == FN_MTLO) || (fn[5:2] == 4'b0110));
            d.dest   = inst[15:11];
            d.is_sys = (fn == FN_SYSCALL);
            d.is_bp  = (fn == FN_BREAK);
        end else if (op == OP_JAL) begin
            d.dest_valid = 1'b1;
            d.dest       = 5'd31;
        end else if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100)) begin
            d.dest_valid = 1'b1;
            d.dest       = inst[20:16];
        end else if ((op == OP_COP0) && (rs == RS_MF)) begin
            d.dest_valid = 1'b1;
            d.dest       = inst[20:16];
            d.is_mfc0    = 1'b1;
        end
        d.is_mtc0 = (op == OP_COP0) && (rs == RS_MT);
        d.is_eret = (inst == INST_ERET);
        d.is_load = (op[5:3] == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/fairy_wb_stage_cp0.sv
// fairy_wb_stage_cp0
//   CP0 register file: Status, Cause, EPC, BadVAddr and (with
//   FAIRY_CP0_TIMER_EN defined) Count/Compare with the IP7 timer interrupt.
// Ports
//   clk, reset_n     clock, synchronous active-low reset
//   mtc0_wen         MTC0 committing this cycle (already gated by exception)
//   cp0_addr         rd field: MTC0 target and MFC0 source
//   wdata            MTC0 write data
//   rdata            MFC0 read data (combinational)
//   exc_commit       exception committing; exc_code/exc_pc describe it
//   badv_wen         exception is AdEL/AdES; badv_data is the bad address
//   eret_commit      ERET committing (clears EXL)
//   int_req          timer interrupt request (IE & ~EXL & IM7 & IP7)
//   epc              current EPC, used as the ERET target
module fairy_wb_stage_cp0
    import fairy_wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_STATUS = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mtc0_wen,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        exc_commit,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        badv_wen,
    input  logic [31:0] badv_data,
    input  logic        eret_commit,
    output logic        int_req,
    output logic [31:0] epc
);

    logic [31:0] status_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;
    logic        ip7_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic [31:0] status_wval;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_status_mask
            assign status_wval[gi] = STATUS_WMASK[gi] & wdata[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            status_reg   <= RESET_STATUS;
            exc_code_reg <= '0;
            epc_reg      <= '0;
            badvaddr_reg <= '0;
        end else if (exc_commit) begin
            exc_code_reg <= exc_code;
            // A nested exception keeps the original return address.
            if (!status_reg[1]) begin
                epc_reg <= exc_pc;
            end
            if (badv_wen) begin
                badvaddr_reg <= badv_data;
            end
            status_reg[1] <= 1'b1;
        end else if (eret_commit) begin
            status_reg[1] <= 1'b0;
        end else if (mtc0_wen) begin
            if (cp0_addr == CP0_STATUS) begin
                status_reg <= status_wval;
            end
            if (cp0_addr == CP0_EPC) begin
                epc_reg <= wdata;
            end
        end
    end

`ifdef FAIRY_CP0_TIMER_EN
    logic tick_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_reg    <= 1'b0;
            count_reg   <= '0;
            compare_reg <= '0;
            ip7_reg     <= 1'b0;
        end else begin
            tick_reg <= ~tick_reg;
            if (mtc0_wen && (cp0_addr == CP0_COUNT)) begin
                count_reg <= wdata;
            end else if (tick_reg) begin
                count_reg <= count_reg + 32'd1;
            end
            if (mtc0_wen && (cp0_addr == CP0_COMPARE)) begin
                compare_reg <= wdata;
            end
            // Writing Compare acknowledges the interrupt and beats a match.
            if (mtc0_wen && (cp0_addr == CP0_COMPARE)) begin
                ip7_reg <= 1'b0;
            end else if (count_reg == compare_reg) begin
                ip7_reg <= 1'b1;
            end
        end
    end
`else
    assign count_reg   = '0;
    assign compare_reg = '0;
    assign ip7_reg     = 1'b0;
`endif

    assign int_req = status_reg[0] & ~status_reg[1] & status_reg[15] & ip7_reg;
    assign epc     = epc_reg;

    always_comb begin
        rdata = '0;
        case (cp0_addr)
            CP0_BADVADDR: rdata = badvaddr_reg;
            CP0_COUNT:    rdata = count_reg;
            CP0_COMPARE:  rdata = compare_reg;
            CP0_STATUS:   rdata = status_reg;
            CP0_CAUSE:    rdata = {16'b0, ip7_reg, 8'b0, exc_code_reg, 2'b0};
            CP0_EPC:      rdata = epc_reg;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/fairy_wb_stage.sv
// fairy_wb_stage
//   Writeback stage: registers the memory-stage result, drives the regfile
//   write port, detects and commits exceptions, executes MFC0/MTC0/ERET and
//   redirects fetch on exception or ERET. Optional CP0 timer interrupt is
//   built when FAIRY_CP0_TIMER_EN is defined.
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   inst_i, data_i,    memory-stage instruction (0 = bubble), result/load
//   pc_i               data (bad address on misalign, rt on MTC0), its PC
//   overflow_i         arithmetic overflow flag
//   unaligned_addr_i   misaligned load/store flag
//   rf_wen_o, rf_waddr_o, rf_wdata_o   regfile write port
//   exception_o        exception taken this cycle; flushes IF..MEM
//   eret_o             ERET committing this cycle
//   redirect_pc_o      EXC_VECTOR on exception, EPC on ERET, else 0
module fairy_wb_stage
    import fairy_wb_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter logic [31:0] RESET_STATUS = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    input  logic        overflow_i,
    input  logic        unaligned_addr_i,
    output logic        rf_wen_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        exception_o,
    output logic        eret_o,
    output logic [31:0] redirect_pc_o
);

    logic [31:0] inst_reg;
    logic [31:0] data_reg;
    logic [31:0] pc_reg;
    logic        ov_reg;
    logic        ua_reg;

    dec_t        dec;
    logic        inst_valid;
    logic        int_req;
    logic [4:0]  exc_code;
    logic [31:0] cp0_rdata;
    logic [31:0] epc;
    logic        flush;

    // The instruction arriving behind an exception or ERET is younger and
    // must not commit, so the stage loads a bubble on that edge.
    assign flush = exception_o | eret_o;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            inst_reg <= '0;
            data_reg <= '0;
            pc_reg   <= '0;
            ov_reg   <= 1'b0;
            ua_reg   <= 1'b0;
        end else begin
            inst_reg <= inst_i;
            data_reg <= data_i;
            pc_reg   <= pc_i;
            ov_reg   <= overflow_i;
            ua_reg   <= unaligned_addr_i;
        end
    end

    assign dec        = decode_inst(inst_reg);
    assign inst_valid = (inst_reg != 32'd0);

    // Priority chain, highest first: Int, AdEL/AdES, Ov, Sys, Bp.
    always_comb begin
        exception_o = 1'b1;
        exc_code    = EXC_INT;
        if (int_req && inst_valid) begin
            exc_code = EXC_INT;
        end else if (ua_reg && inst_valid) begin
            exc_code = dec.is_load ? EXC_ADEL : EXC_ADES;
        end else if (ov_reg && inst_valid) begin
            exc_code = EXC_OV;
        end else if (dec.is_sys) begin
            exc_code = EXC_SYS;
        end else if (dec.is_bp) begin
            exc_code = EXC_BP;
        end else begin
            exception_o = 1'b0;
        end
    end

    assign eret_o = dec.is_eret & ~exception_o;

    always_comb begin
        redirect_pc_o = '0;
        if (exception_o) begin
            redirect_pc_o = EXC_VECTOR;
        end else if (eret_o) begin
            redirect_pc_o = epc;
        end
    end

    assign rf_waddr_o = dec.dest_valid ? dec.dest : 5'd0;
    assign rf_wen_o   = dec.dest_valid & (dec.dest != 5'd0) & ~exception_o;
    assign rf_wdata_o = dec.is_mfc0 ? cp0_rdata : data_reg;

    fairy_wb_stage_cp0 #(
        .RESET_STATUS (RESET_STATUS)
    ) u_cp0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .mtc0_wen    (dec.is_mtc0 & ~exception_o),
        .cp0_addr    (inst_reg[15:11]),
        .wdata       (data_reg),
        .rdata       (cp0_rdata),
        .exc_commit  (exception_o),
        .exc_code    (exc_code),
        .exc_pc      (pc_reg),
        .badv_wen    (ua_reg & inst_valid & ~(int_req & inst_valid)),
        .badv_data   (data_reg),
        .eret_commit (eret_o),
        .int_req     (int_req),
        .epc         (epc)
    );

endmodule

// File: tb/tb_fairy_wb_stage.sv
// tb_fairy_wb_stage
//   Directed bench for fairy_wb_stage. A vector table drives one
//   instruction followed by a bubble cycle and checks the registered
//   outputs; hand-written sequences cover squashing, back-to-back
//   MTC0/MFC0, the timer build and reset during an exception.
module tb_fairy_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] inst_i, data_i, pc_i;
    logic        overflow_i, unaligned_addr_i;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        exception_o, eret_o;
    logic [31:0] redirect_pc_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fairy_wb_stage dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .inst_i           (inst_i),
        .data_i           (data_i),
        .pc_i             (pc_i),
        .overflow_i       (overflow_i),
        .unaligned_addr_i (unaligned_addr_i),
        .rf_wen_o         (rf_wen_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .exception_o      (exception_o),
        .eret_o           (eret_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    localparam logic [31:0] VEC    = 32'hBFC00380;
    localparam logic [31:0] I_ADDU3 = 32'h00221821;
    localparam logic [31:0] I_ADD3  = 32'h00221820;
    localparam logic [31:0] I_ADDIU = 32'h24040005;
    localparam logic [31:0] I_LW6   = 32'h8C060000;
    localparam logic [31:0] I_SW    = 32'hAC010000;
    localparam logic [31:0] I_JAL   = 32'h0C000010;
    localparam logic [31:0] I_JR    = 32'h03E00008;
    localparam logic [31:0] I_MULT  = 32'h00850018;
    localparam logic [31:0] I_SYS   = 32'h0000000C;
    localparam logic [31:0] I_BRK   = 32'h0000000D;
    localparam logic [31:0] I_ERET  = 32'h42000018;
    localparam logic [31:0] MF_ST   = 32'h40056000;  // mfc0 r5, Status
    localparam logic [31:0] MF_CA   = 32'h40096800;  // mfc0 r9, Cause
    localparam logic [31:0] MF_EPC  = 32'h40077000;  // mfc0 r7, EPC
    localparam logic [31:0] MF_BV   = 32'h40084000;  // mfc0 r8, BadVAddr
    localparam logic [31:0] MF_CNT  = 32'h400A4800;  // mfc0 r10, Count
    localparam logic [31:0] MF_CMP  = 32'h400B5800;  // mfc0 r11, Compare
    localparam logic [31:0] MF_PRID = 32'h400C7800;  // mfc0 r12, reg 15
    localparam logic [31:0] MF_ST0  = 32'h40006000;  // mfc0 r0, Status
    localparam logic [31:0] MT_ST   = 32'h40806000;
    localparam logic [31:0] MT_EPC  = 32'h40807000;
    localparam logic [31:0] MT_CNT  = 32'h40804800;
    localparam logic [31:0] MT_CMP  = 32'h40805800;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] data;
        logic [31:0] pc;
        logic        ov;
        logic        ua;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exc;
        logic        eret;
        logic [31:0] redir;
    } vec_t;

    vec_t vecs[36];

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] data,
                                input logic [31:0] pc, input logic ov, input logic ua,
                                input logic wen, input logic [4:0] waddr,
                                input logic [31:0] wdata, input logic exc,
                                input logic eret, input logic [31:0] redir);
        vec_t v;
        v.inst = inst; v.data = data; v.pc = pc; v.ov = ov; v.ua = ua;
        v.wen = wen; v.waddr = waddr; v.wdata = wdata;
        v.exc = exc; v.eret = eret; v.redir = redir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] data,
                         input logic [31:0] pc, input logic ov, input logic ua);
        inst_i = inst; data_i = data; pc_i = pc;
        overflow_i = ov; unaligned_addr_i = ua;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic wen, input logic [4:0] waddr,
                            input logic [31:0] wdata, input logic exc, input logic eret,
                            input logic [31:0] redir);
        chk({tag, ".wen"},   32'(rf_wen_o),      32'(wen));
        chk({tag, ".waddr"}, 32'(rf_waddr_o),    32'(waddr));
        chk({tag, ".wdata"}, rf_wdata_o,         wdata);
        chk({tag, ".exc"},   32'(exception_o),   32'(exc));
        chk({tag, ".eret"},  32'(eret_o),        32'(eret));
        chk({tag, ".redir"}, redirect_pc_o,      redir);
    endtask

    // One instruction, compare its writeback outputs for a named register read.
    task automatic mfc0_chk(input string tag, input logic [31:0] inst, input logic [31:0] exp);
        drive(inst, 32'd0, 32'h0, 1'b0, 1'b0);
        tick();
        chk(tag, rf_wdata_o, exp);
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        // inst, data, pc, ov, ua | wen, waddr, wdata, exc, eret, redirect
        vecs[0]  = mk(I_ADDU3, 32'h1234, 32'h80, 0, 0,   1, 3,  32'h1234, 0, 0, 0);
        vecs[1]  = mk(I_ADDIU, 32'h5, 32'h84, 0, 0,      1, 4,  32'h5, 0, 0, 0);
        vecs[2]  = mk(I_LW6, 32'hABCD, 32'h88, 0, 0,     1, 6,  32'hABCD, 0, 0, 0);
        vecs[3]  = mk(I_JAL, 32'h88, 32'h8C, 0, 0,       1, 31, 32'h88, 0, 0, 0);
        vecs[4]  = mk(I_JR, 32'h77, 32'h90, 0, 0,        0, 0,  32'h77, 0, 0, 0);
        vecs[5]  = mk(I_MULT, 32'h0, 32'h94, 0, 0,       0, 0,  32'h0, 0, 0, 0);
        vecs[6]  = mk(I_SW, 32'h55, 32'h98, 0, 0,        0, 0,  32'h55, 0, 0, 0);
        vecs[7]  = mk(MF_ST, 0, 32'h9C, 0, 0,            1, 5,  32'h00400000, 0, 0, 0);
        vecs[8]  = mk(MF_CA, 0, 32'hA0, 0, 0,            1, 9,  32'h0, 0, 0, 0);
        vecs[9]  = mk(I_LW6, 32'h1002, 32'h100, 0, 1,    0, 6,  32'h1002, 1, 0, VEC);
        vecs[10] = mk(MF_EPC, 0, 32'h0, 0, 0,            1, 7,  32'h100, 0, 0, 0);
        vecs[11] = mk(MF_BV, 0, 32'h0, 0, 0,             1, 8,  32'h1002, 0, 0, 0);
        vecs[12] = mk(MF_CA, 0, 32'h0, 0, 0,             1, 9,  32'h10, 0, 0, 0);
        vecs[13] = mk(MF_ST, 0, 32'h0, 0, 0,             1, 5,  32'h00400002, 0, 0, 0);
        vecs[14] = mk(I_ADD3, 32'h99, 32'h200, 1, 0,     0, 3,  32'h99, 1, 0, VEC);
        vecs[15] = mk(MF_CA, 0, 32'h0, 0, 0,             1, 9,  32'h30, 0, 0, 0);
        vecs[16] = mk(MF_EPC, 0, 32'h0, 0, 0,            1, 7,  32'h100, 0, 0, 0);
        vecs[17] = mk(I_ERET, 0, 32'h300, 0, 0,          0, 0,  32'h0, 0, 1, 32'h100);
        vecs[18] = mk(MF_ST, 0, 32'h0, 0, 0,             1, 5,  32'h00400000, 0, 0, 0);
        vecs[19] = mk(I_SW, 32'h2003, 32'h400, 0, 1,     0, 0,  32'h2003, 1, 0, VEC);
        vecs[20] = mk(MF_CA, 0, 32'h0, 0, 0,             1, 9,  32'h14, 0, 0, 0);
        vecs[21] = mk(MF_EPC, 0, 32'h0, 0, 0,            1, 7,  32'h400, 0, 0, 0);
        vecs[22] = mk(I_ERET, 0, 32'h404, 0, 0,          0, 0,  32'h0, 0, 1, 32'h400);
        vecs[23] = mk(I_SYS, 0, 32'h500, 0, 0,           0, 0,  32'h0, 1, 0, VEC);
        vecs[24] = mk(MF_CA, 0, 32'h0, 0, 0,             1, 9,  32'h20, 0, 0, 0);
        vecs[25] = mk(I_ERET, 0, 32'h504, 0, 0,          0, 0,  32'h0, 0, 1, 32'h500);
        vecs[26] = mk(I_BRK, 0, 32'h600, 0, 0,           0, 0,  32'h0, 1, 0, VEC);
        vecs[27] = mk(MF_CA, 0, 32'h0, 0, 0,             1, 9,  32'h24, 0, 0, 0);
        vecs[28] = mk(I_ERET, 0, 32'h604, 0, 0,          0, 0,  32'h0, 0, 1, 32'h600);
        vecs[29] = mk(MT_ST, 32'h8001, 32'h700, 0, 0,    0, 0,  32'h8001, 0, 0, 0);
        vecs[30] = mk(MF_ST, 0, 32'h0, 0, 0,             1, 5,  32'h00008001, 0, 0, 0);
        vecs[31] = mk(32'h0, 32'h33, 32'h0, 1, 1,        0, 0,  32'h33, 0, 0, 0);
        vecs[32] = mk(MT_EPC, 32'hDEAD0000, 32'h0, 0, 0, 0, 0,  32'hDEAD0000, 0, 0, 0);
        vecs[33] = mk(MF_EPC, 0, 32'h0, 0, 0,            1, 7,  32'hDEAD0000, 0, 0, 0);
        vecs[34] = mk(MF_PRID, 0, 32'h0, 0, 0,           1, 12, 32'h0, 0, 0, 0);
        vecs[35] = mk(MF_ST0, 0, 32'h0, 0, 0,            0, 0,  32'h00008001, 0, 0, 0);

        // Reset state
        reset_n = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 36; i++) begin
            drive(vecs[i].inst, vecs[i].data, vecs[i].pc, vecs[i].ov, vecs[i].ua);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].wen, vecs[i].waddr, vecs[i].wdata,
                     vecs[i].exc, vecs[i].eret, vecs[i].redir);
            $display("vec %0d inst=%h wen=%0d waddr=%0d wdata=%h exc=%0d eret=%0d redir=%h",
                     i, vecs[i].inst, rf_wen_o, rf_waddr_o, rf_wdata_o,
                     exception_o, eret_o, redirect_pc_o);
            drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
        end

        // Younger instruction right behind an exception is squashed.
        drive(I_LW6, 32'h3000, 32'h700, 1'b0, 1'b1);
        tick();
        chk("squash.exc", 32'(exception_o), 32'd1);
        drive(I_ADDU3, 32'h4444, 32'h704, 1'b0, 1'b0);
        tick();
        chk_outs("squash.next", 0, 0, 0, 0, 0, 0);
        $display("seq squash wen=%0d wdata=%h", rf_wen_o, rf_wdata_o);
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        mfc0_chk("squash.epc", MF_EPC, 32'h700);
        drive(I_ERET, 32'd0, 32'h708, 1'b0, 1'b0);
        tick();
        chk("squash.eret_redir", redirect_pc_o, 32'h700);
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();

        // MTC0 immediately followed by MFC0 of the same register.
        drive(MT_ST, 32'hFFFFFFFF, 32'h800, 1'b0, 1'b0);
        tick();
        drive(MF_ST, 32'd0, 32'h804, 1'b0, 1'b0);
        tick();
        chk("b2b.wdata", rf_wdata_o, 32'h0000FF03);
        chk("b2b.wen", 32'(rf_wen_o), 32'd1);
        $display("seq b2b mfc0 status=%h", rf_wdata_o);
        drive(I_ERET, 32'd0, 32'h808, 1'b0, 1'b0);
        tick();
        chk("b2b.eret", 32'(eret_o), 32'd1);
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        mfc0_chk("b2b.status_after_eret", MF_ST, 32'h0000FF01);

`ifdef FAIRY_CP0_TIMER_EN
        // Timer: Compare=10, Count=0, then run instructions until Int.
        begin
            bit seen;
            seen = 1'b0;
            drive(MT_CMP, 32'd10, 32'h900, 1'b0, 1'b0);
            tick();
            drive(MT_CNT, 32'd0, 32'h904, 1'b0, 1'b0);
            tick();
            drive(I_ADDU3, 32'h1, 32'hA00, 1'b0, 1'b0);
            for (int c = 0; c < 60 && !seen; c++) begin
                tick();
                if (exception_o) seen = 1'b1;
            end
            chk("timer.int_taken", 32'(seen), 32'd1);
            drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
            mfc0_chk("timer.cause", MF_CA, 32'h00008000);
            drive(MT_CMP, 32'hFFFF0000, 32'hA10, 1'b0, 1'b0);
            tick();
            drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
            mfc0_chk("timer.cause_cleared", MF_CA, 32'h0);
            $display("seq timer int_seen=%0d", seen);
        end
`else
        // Without the timer, Count/Compare ignore writes and read 0.
        drive(MT_CMP, 32'd5, 32'h900, 1'b0, 1'b0);
        tick();
        drive(MT_CNT, 32'd7, 32'h904, 1'b0, 1'b0);
        tick();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        mfc0_chk("notimer.compare", MF_CMP, 32'h0);
        mfc0_chk("notimer.count", MF_CNT, 32'h0);
        mfc0_chk("notimer.cause", MF_CA, 32'h10);
        $display("seq notimer count/compare read back zero checked");
`endif

        // Reset asserted while an exception is being presented.
        drive(I_SYS, 32'd0, 32'hB00, 1'b0, 1'b0);
        tick();
        chk("rst_exc.exc", 32'(exception_o), 32'd1);
        reset_n = 1'b0;
        drive(I_ADDU3, 32'h5555, 32'hB04, 1'b0, 1'b0);
        tick();
        chk_outs("rst_exc.out", 0, 0, 0, 0, 0, 0);
        $display("seq reset_mid_exception exc=%0d wen=%0d", exception_o, rf_wen_o);
        reset_n = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        mfc0_chk("rst_exc.status", MF_ST, 32'h00400000);
`ifdef FAIRY_CP0_TIMER_EN
        mfc0_chk("rst_exc.cause", MF_CA, 32'h00008000);
`else
        mfc0_chk("rst_exc.cause", MF_CA, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
